// File: rtl/regctrl_pkg.sv
// Shared definitions for the register-block control sequencer: opcodes,
// FSM state encoding, instruction field positions and register indices.
package regctrl_pkg;

   localparam int INSTR_W = 4;

   localparam logic [1:0] OP_LDX = 2'b00;
   localparam logic [1:0] OP_MOV = 2'b01;
   localparam logic [1:0] OP_OUT = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam int OP_MSB  = 3;
   localparam int OP_LSB  = 2;
   localparam int DST_BIT = 1;
   localparam int SRC_BIT = 0;

   localparam logic REG1 = 1'b0;
   localparam logic REG2 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WR,
      ST_HOLD,
      ST_DONE
   } state_e;

endpackage

// File: rtl/regctrl_skid_buf.sv
// One-entry instruction buffer holding a micro-instruction accepted while
// the sequencer is busy; ready whenever the entry is empty.
module regctrl_skid_buf
   import regctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push_i,
   input  logic [INSTR_W-1:0] data_i,
   input  logic               pop_i,
   output logic               vld_o,
   output logic [INSTR_W-1:0] data_o,
   output logic               ready_o
);

   logic               vld_q, vld_d;
   logic [INSTR_W-1:0] data_q, data_d;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (push_i) begin
         vld_d  = 1'b1;
         data_d = data_i;
      end else if (pop_i) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign vld_o   = vld_q;
   assign data_o  = data_q;
   assign ready_o = ~vld_q;

endmodule

// File: rtl/regfile_ctrl_sequencer.sv
// Micro-instruction sequencer driving the two-entry register block's enables.
// Optional REGCTRL_SKID_EN adds a one-entry buffer for back-to-back issue.
// The external-bus control is named extern_en because extern is a reserved word.
module regfile_ctrl_sequencer
   import regctrl_pkg::*;
#(
   parameter int SETTLE   = 1,
   parameter int OUT_HOLD = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       instr_valid,
   input  logic [3:0] instr,
   output logic       instr_ready,
   output logic       write_enable_1,
   output logic       write_enable_2,
   output logic       read_enable_1,
   output logic       read_enable_2,
   output logic       extern_en,
   output logic       busy,
   output logic       done,
   output logic [1:0] done_op,
   output logic       ill_op
);

   localparam int CNT_MAX = (SETTLE > OUT_HOLD) ? SETTLE : OUT_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(OUT_HOLD);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             dst_q, dst_d;
   logic             src_q, src_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic               start;
   logic [INSTR_W-1:0] start_instr;
   logic               we_dst, re_src;

`ifdef REGCTRL_SKID_EN
   logic               accept, can_start;
   logic               buf_push, buf_pop, buf_vld, buf_ready;
   logic [INSTR_W-1:0] buf_data;

   // A held instruction takes priority at DONE; new work goes straight in
   // when the FSM can start it this edge, otherwise it is parked.
   assign can_start   = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign instr_ready = buf_ready;
   assign accept      = instr_valid && buf_ready;
   assign buf_pop     = (state_q == ST_DONE) && buf_vld;
   assign buf_push    = accept && !can_start;
   assign start       = buf_pop || (accept && can_start);
   assign start_instr = buf_pop ? buf_data : instr;

   regctrl_skid_buf u_skid_buf (
      .clk     (clk),
      .reset   (reset),
      .push_i  (buf_push),
      .data_i  (instr),
      .pop_i   (buf_pop),
      .vld_o   (buf_vld),
      .data_o  (buf_data),
      .ready_o (buf_ready)
   );
`else
   assign instr_ready = (state_q == ST_IDLE);
   assign start       = instr_valid && instr_ready;
   assign start_instr = instr;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dst_d   = dst_q;
      src_d   = src_q;
      ill_d   = ill_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;

      case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_SETTLE: if (cnt_q <= CNT_ONE) state_d = ST_WR;
         ST_WR:     state_d = ST_DONE;
         ST_HOLD:   if (cnt_q <= CNT_ONE) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (start) begin
         op_d  = start_instr[OP_MSB:OP_LSB];
         dst_d = start_instr[DST_BIT];
         src_d = start_instr[SRC_BIT];
         ill_d = 1'b0;
         cnt_d = '0;
         case (start_instr[OP_MSB:OP_LSB])
            OP_LDX: state_d = ST_WR;
            OP_MOV: begin
               // Self-move would drive and load the same register; reject it.
               if (start_instr[DST_BIT] == start_instr[SRC_BIT]) begin
                  state_d = ST_DONE;
                  ill_d   = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_C;
               end
            end
            OP_OUT: begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_C;
            end
            default: state_d = ST_DONE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q  <= op_d;
      dst_q <= dst_d;
      src_q <= src_d;
   end

   always_comb begin
      we_dst    = 1'b0;
      re_src    = 1'b0;
      extern_en = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_SETTLE: re_src = 1'b1;
         ST_WR: begin
            we_dst    = 1'b1;
            re_src    = (op_q == OP_MOV);
            extern_en = (op_q == OP_LDX);
         end
         ST_HOLD: begin
            re_src    = 1'b1;
            extern_en = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign write_enable_1 = we_dst && (dst_q == REG1);
   assign write_enable_2 = we_dst && (dst_q == REG2);
   assign read_enable_1  = re_src && (src_q == REG1);
   assign read_enable_2  = re_src && (src_q == REG2);
   assign busy           = (state_q != ST_IDLE);
   assign done_op        = op_q;
   assign ill_op         = done && ill_q;

endmodule
